// File: rtl/dram_read_responder.sv
// dram_read_responder: DRAM-side AXI-style read responder.
// AR requests are queued in a small FIFO. Each burst is served one beat at a
// time: FETCH does a synchronous memory read, and SEND presents the R beat.
// A backdoor port preloads the word memory.
module dram_read_responder #(
  parameter int DEPTH    = 4096,
  parameter int AR_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_arvld,
  output logic        axi_arrdy,
  input  logic [7:0]  axi_arid,
  input  logic [11:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  output logic        axi_rvld,
  input  logic        axi_rrdy,
  output logic [7:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  input  logic        mem_wen,
  input  logic [11:0] mem_waddr,
  input  logic [31:0] mem_wdata,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(AR_DEPTH);
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(AR_DEPTH);

  typedef struct packed {
    logic [7:0]  id;
    logic [11:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  logic [31:0]   mem [DEPTH];
  ar_req_t       fifo [AR_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          push, pop, fifo_empty, fifo_full;

  state_t        state;
  ar_req_t       cur;
  logic [7:0]    beat_cnt;
  logic [11:0]   cur_addr;
  logic          addr_err, size_err;

  assign fifo_full  = (cnt == FIFO_FULL);
  assign fifo_empty = (cnt == '0);
  // A full FIFO is never ready, even when the FSM pops in the same cycle.
  assign axi_arrdy  = ~fifo_full & ~rst;
  assign push       = axi_arvld & axi_arrdy;
  assign pop        = (state == IDLE) & ~fifo_empty;
  assign busy       = ~fifo_empty | (state != IDLE);
  assign addr_err   = 32'(cur_addr) >= DEPTH;
  assign size_err   = (cur.size != 3'b010);

  // Backdoor preload. Out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (mem_wen && (32'(mem_waddr) < DEPTH))
      mem[mem_waddr[AW-1:0]] <= mem_wdata;
  end

  // AR request FIFO: the occupancy counter tracks push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{id: axi_arid, addr: axi_araddr, len: axi_arlen,
                          size: axi_arsize, burst: axi_arburst};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Burst FSM with registered R outputs. The memory read in FETCH sees the
  // pre-write value when a backdoor write hits the same word (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      beat_cnt  <= '0;
      cur_addr  <= '0;
      axi_rvld  <= 1'b0;
      axi_rlast <= 1'b0;
      axi_rid   <= '0;
      axi_rdata <= '0;
      axi_rresp <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur      <= fifo[rd_ptr];
            cur_addr <= fifo[rd_ptr].addr;
            beat_cnt <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          axi_rvld  <= 1'b1;
          axi_rid   <= cur.id;
          axi_rlast <= (beat_cnt == cur.len);
          if (addr_err || size_err) begin
            axi_rdata <= '0;
            axi_rresp <= 2'b10;
          end else begin
            axi_rdata <= mem[cur_addr[AW-1:0]];
            axi_rresp <= 2'b00;
          end
          state <= SEND;
        end
        SEND: begin
          if (axi_rrdy) begin
            axi_rvld <= 1'b0;
            if (beat_cnt == cur.len) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              if (cur.burst != 2'b00) cur_addr <= cur_addr + 12'd1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_read_responder.sv
// Scoreboard bench for dram_read_responder. Two instances are used: the
// default DEPTH=4096 and a DEPTH=16 one for out-of-range beats. The shared
// backdoor writes go to both instances.
module tb_dram_read_responder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        arvld = 1'b0, s_arvld = 1'b0, rrdy = 1'b0;
  logic [7:0]  arid = '0, arlen = '0;
  logic [11:0] araddr = '0, mem_waddr = '0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_wdata = '0;

  logic        arrdy, rvld, rlast, busy;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        s_arrdy, s_rvld, s_rlast, s_busy;
  logic [7:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  always #5 clk = ~clk;

  dram_read_responder u_dut (
    .clk(clk), .rst(rst), .axi_arvld(arvld), .axi_arrdy(arrdy), .axi_arid(arid),
    .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
    .axi_rvld(rvld), .axi_rrdy(rrdy), .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp),
    .axi_rlast(rlast), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy));

  dram_read_responder #(.DEPTH(16)) u_small (
    .clk(clk), .rst(rst), .axi_arvld(s_arvld), .axi_arrdy(s_arrdy), .axi_arid(arid),
    .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
    .axi_rvld(s_rvld), .axi_rrdy(rrdy), .axi_rid(s_rid), .axi_rdata(s_rdata),
    .axi_rresp(s_rresp), .axi_rlast(s_rlast), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .busy(s_busy));

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        first;
  } beat_t;

  beat_t       exp_q[$], exp_s[$];
  logic [31:0] mdl [4096];
  int          n_tests = 0, n_fail = 0, cyc = 0, hs_cyc = 0, last_acc = 0;
  bit          chk_lat = 0, chk_gap = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
    mem_wen = 1'b1; mem_waddr = a; mem_wdata = d;
    @(posedge clk); #1;
    mem_wen = 1'b0;
    mdl[a] = d;
  endtask

  // Issue one AR and queue the expected beats for the selected instance.
  task automatic ar(input bit sel, input logic [7:0] id, input logic [11:0] a,
                    input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    bit ok = 0;
    logic [11:0] ba;
    bit err;
    beat_t e;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu;
    if (sel) s_arvld = 1'b1; else arvld = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sel ? s_arrdy : arrdy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL ar_handshake_timeout: id %0h never accepted", id);
    end else begin
      hs_cyc = cyc;
      for (int b = 0; b <= int'(len); b++) begin
        ba      = (bu == 2'b00) ? a : a + 12'(b);
        err     = (sz != 3'b010) || (sel && ba >= 12'd16);
        e.id    = id;
        e.data  = err ? 32'h0 : mdl[ba];
        e.resp  = err ? 2'b10 : 2'b00;
        e.last  = (b == int'(len));
        e.first = (b == 0);
        if (sel) exp_s.push_back(e); else exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    arvld = 1'b0; s_arvld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && exp_s.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_main", 64'(exp_q.size()), 64'(0));
    chk("drain_small", 64'(exp_s.size()), 64'(0));
    @(posedge clk); #1;
    chk("idle_busy", 64'({busy, s_busy}), 64'(0));
  endtask

  // Main-instance monitor: pops on every accepted beat; checks the hold
  // stability, the first-beat latency and the inter-beat gap.
  logic        hold_p = 0, rvld_p = 0, h_last = 0;
  logic [7:0]  h_id = 0;
  logic [31:0] h_data = 0;
  logic [1:0]  h_resp = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst && hold_p)
      chk("r_hold_stable", 64'({rvld, rid, rdata, rresp, rlast}),
          64'({1'b1, h_id, h_data, h_resp, h_last}));
    if (!rst && chk_lat && rvld && !rvld_p) begin
      chk("first_rvld_latency", 64'(cyc - hs_cyc), 64'(3));
      chk_lat = 0;
    end
    if (!rst && rvld && rrdy) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL r_unexpected: got beat id %0h data %0h, none expected", rid, rdata);
      end else begin
        e = exp_q.pop_front();
        chk("r_beat", 64'({rid, rdata, rresp, rlast}), 64'({e.id, e.data, e.resp, e.last}));
        if (chk_gap && !e.first) chk("beat_gap", 64'(cyc - last_acc), 64'(2));
      end
      last_acc = cyc;
    end
    hold_p = rvld && !rrdy && !rst;
    h_id = rid; h_data = rdata; h_resp = rresp; h_last = rlast;
    rvld_p = rvld;
  end

  // Small-instance monitor.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && s_rvld && rrdy) begin
      if (exp_s.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL s_unexpected: got beat id %0h data %0h, none expected", s_rid, s_rdata);
      end else begin
        e = exp_s.pop_front();
        chk("s_beat", 64'({s_rid, s_rdata, s_rresp, s_rlast}),
            64'({e.id, e.data, e.resp, e.last}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_r_outputs", 64'({rvld, rlast, rid, rdata, rresp}), 64'(0));
    chk("reset_busy_arrdy", 64'({busy, arrdy, s_busy, s_arrdy, s_rvld}), 64'(0));
    rst = 1'b0;
    #1;
    chk("arrdy_after_reset", 64'({arrdy, s_arrdy}), 64'(2'b11));

    for (int i = 0; i < 4; i++) bd_write(12'h010 + 12'(i), 32'hA0A0_0000 + 32'(i));
    bd_write(12'h020, 32'h0000_CAFE);
    bd_write(12'h00E, 32'hE0E0_000E);
    bd_write(12'h00F, 32'hF0F0_000F);
    bd_write(12'hFFF, 32'h5A5A_0FFF);
    bd_write(12'h000, 32'h1234_0000);
    for (int i = 0; i < 10; i++) bd_write(12'h100 + 12'(i), 32'hB000_0100 + 32'(i));

    // INCR burst of 4 with latency and gap checks
    rrdy = 1'b1; chk_lat = 1; chk_gap = 1;
    ar(0, 8'h05, 12'h010, 8'd3, 3'b010, 2'b01);
    drain();
    chk("latency_checked", 64'(chk_lat), 64'(0));

    // FIXED burst of 3
    ar(0, 8'h07, 12'h020, 8'd2, 3'b010, 2'b00);
    drain();

    // DEPTH=16 instance: beats at 0x10/0x11 are out of range
    ar(1, 8'h09, 12'h00E, 8'd3, 3'b010, 2'b01);
    drain();

    // Unsupported size, then address wrap 0xFFF -> 0x000
    ar(0, 8'h03, 12'h010, 8'd1, 3'b001, 2'b01);
    ar(0, 8'h04, 12'hFFF, 8'd1, 3'b010, 2'b01);
    drain();
    chk_gap = 0;

    // Back-to-back ARs with R stalled: one burst in flight + 4 queued = full
    rrdy = 1'b0;
    for (int i = 0; i < 5; i++)
      ar(0, 8'h10 + 8'(i), 12'h100 + 12'(2 * i), 8'd1, 3'b010, 2'b01);
    chk("fifo_full_arrdy", 64'({arrdy, busy}), 64'(2'b01));
    repeat (6) @(posedge clk);
    #1;
    chk("stall_rvld", 64'(rvld), 64'(1));
    rrdy = 1'b1;
    drain();

    // Reset during beat 2 of 4 with two requests queued
    rrdy = 1'b0;
    ar(0, 8'h20, 12'h010, 8'd3, 3'b010, 2'b01);
    ar(0, 8'h21, 12'h100, 8'd0, 3'b010, 2'b01);
    ar(0, 8'h22, 12'h101, 8'd0, 3'b010, 2'b01);
    for (int k = 0; k < 2; k++) begin
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        if (rvld) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      chk("rvld_wait", 64'(ok), 64'(1));
      if (k == 0) begin
        rrdy = 1'b1;
        @(posedge clk); #1;
        rrdy = 1'b0;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_burst_reset", 64'({rvld, busy, arrdy}), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arrdy_after_abort", 64'(arrdy), 64'(1));

    // Clean restart: single-beat burst (arlen=0)
    rrdy = 1'b1;
    ar(0, 8'h30, 12'h020, 8'd0, 3'b010, 2'b01);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
